// File: rtl/scanout_timing_if.sv
// Pixel-stream bundle between the scanout timing generator and its consumer.
// The timing generator is the master; the framebuffer reader/display side is the slave.
interface scanout_timing_if #(
  parameter int ADDR_W = 24
);
  logic              fbHDMI;
  logic              hSync;
  logic              vSync;
  logic              de;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              readEn;
  logic [ADDR_W-1:0] readAddr;
  logic              fbShown;
  logic              frameStart;

  modport master (
    input  fbHDMI,
    output hSync, vSync, de, x, y, readEn, readAddr, fbShown, frameStart
  );

  modport slave (
    output fbHDMI,
    input  hSync, vSync, de, x, y, readEn, readAddr, fbShown, frameStart
  );
endinterface

// File: rtl/scanout_timing.sv
// Raster timing generator with double-buffered framebuffer scanout.
// All outputs are registered one clock behind the hCount/vCount raster counters.
module scanout_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int FB_BASE0 = 0,
  parameter int FB_BASE1 = 307200,
  parameter int ADDR_W   = 24
) (
  input logic             clk,
  input logic             reset,
  scanout_timing_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [ADDR_W-1:0] BASE0  = ADDR_W'(FB_BASE0);
  localparam logic [ADDR_W-1:0] BASE1  = ADDR_W'(FB_BASE1);

  logic [HW-1:0]     hCount;
  logic [VW-1:0]     vCount;
  logic [ADDR_W-1:0] addrPtr;
  logic [ADDR_W-1:0] curAddr;
  logic              atOrigin;
  logic              visible;
  logic              hSyncNext;
  logic              vSyncNext;

  // addrPtr holds the address of the next visible pixel; at (0,0) the
  // base is taken straight from fbHDMI so the first pixel needs no bubble.
  always_comb begin
    atOrigin  = (hCount == '0) && (vCount == '0);
    visible   = (hCount < H_ACT) && (vCount < V_ACT);
    hSyncNext = (hCount >= H_SYNC_ON) && (hCount < H_SYNC_OFF);
    vSyncNext = (vCount >= V_SYNC_ON) && (vCount < V_SYNC_OFF);
    curAddr   = addrPtr;
    if (atOrigin) begin
      curAddr = bus.fbHDMI ? BASE1 : BASE0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hCount         <= '0;
      vCount         <= '0;
      addrPtr        <= '0;
      bus.hSync      <= 1'b0;
      bus.vSync      <= 1'b0;
      bus.de         <= 1'b0;
      bus.readEn     <= 1'b0;
      bus.frameStart <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.readAddr   <= '0;
      bus.fbShown    <= 1'b0;
    end else begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + VW'(1);
      end else begin
        hCount <= hCount + HW'(1);
      end

      bus.hSync      <= hSyncNext;
      bus.vSync      <= vSyncNext;
      bus.de         <= visible;
      bus.readEn     <= visible;
      bus.frameStart <= atOrigin;
      bus.x          <= visible ? 10'(hCount) : 10'd0;
      bus.y          <= visible ? 10'(vCount) : 10'd0;
      bus.readAddr   <= visible ? curAddr : '0;

      if (visible) begin
        addrPtr <= curAddr + ADDR_W'(1);
      end
      // The shown buffer is only ever sampled at frame origin: no mid-frame switch.
      if (atOrigin) begin
        bus.fbShown <= bus.fbHDMI;
      end
    end
  end
endmodule

// File: tb/tb_scanout_timing.sv
// Directed bench: scaled-down rasters checked cycle by cycle against a raster
// formula, plus a short run of the default 640x480 timing.
module tb_scanout_timing;
  // Main DUT: 16x6 visible, 24x10 total, frame = 240 clocks.
  localparam int MHA = 16, MHF = 2, MHS = 3, MHB = 3;
  localparam int MVA = 6,  MVF = 1, MVS = 2, MVB = 1;
  localparam int MB0 = 5,  MB1 = 200, MAW = 12;
  // Small DUT: 4x3 visible, 7x6 total, frame = 42 clocks, 4-bit address wraps.
  localparam int SHA = 4, SHF = 1, SHS = 1, SHB = 1;
  localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;
  localparam int SB0 = 0, SB1 = 12, SAW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nVec = 0;
  int   nErr = 0;

  always #5 clk = ~clk;

  scanout_timing_if #(.ADDR_W(MAW)) mIf ();
  scanout_timing_if #(.ADDR_W(SAW)) sIf ();
  scanout_timing_if #(.ADDR_W(24))  dIf ();

  scanout_timing #(
    .H_ACTIVE(MHA), .H_FRONT(MHF), .H_SYNC(MHS), .H_BACK(MHB),
    .V_ACTIVE(MVA), .V_FRONT(MVF), .V_SYNC(MVS), .V_BACK(MVB),
    .FB_BASE0(MB0), .FB_BASE1(MB1), .ADDR_W(MAW)
  ) dutM (.clk(clk), .reset(reset), .bus(mIf));

  scanout_timing #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .FB_BASE0(SB0), .FB_BASE1(SB1), .ADDR_W(SAW)
  ) dutS (.clk(clk), .reset(reset), .bus(sIf));

  scanout_timing dutD (.clk(clk), .reset(reset), .bus(dIf));

  // Expected output vector k clocks after the first post-reset edge:
  // {hSync, vSync, de, readEn, frameStart, fbShown, x, y, readAddr(when de)}
  function automatic logic [49:0] expVec(input int k, input int ha, input int hf,
      input int hs, input int hb, input int va, input int vf, input int vs,
      input int vb, input int b0, input int b1, input bit fb, input int aw);
    int ht, vt, h, v, a;
    logic d, hsE, vsE, fsE;
    logic [23:0] am, mask;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = k % ht;
    v    = (k / ht) % vt;
    d    = (h < ha) && (v < va);
    hsE  = (h >= ha + hf) && (h < ha + hf + hs);
    vsE  = (v >= va + vf) && (v < va + vf + vs);
    fsE  = (h == 0) && (v == 0);
    a    = (fb ? b1 : b0) + v * ha + h;
    mask = (aw >= 24) ? 24'hFFFFFF : 24'((1 << aw) - 1);
    am   = 24'(a) & mask;
    return {hsE, vsE, d, d, fsE, fb, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0,
            d ? am : 24'd0};
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [49:0] obsM, obsS, obsD;
    mIf.fbHDMI = 1'b0; sIf.fbHDMI = 1'b0; dIf.fbHDMI = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obsM = {mIf.hSync, mIf.vSync, mIf.de, mIf.readEn, mIf.frameStart, mIf.fbShown, mIf.x, mIf.y, 24'(mIf.readAddr)};
    obsS = {sIf.hSync, sIf.vSync, sIf.de, sIf.readEn, sIf.frameStart, sIf.fbShown, sIf.x, sIf.y, 24'(sIf.readAddr)};
    obsD = {dIf.hSync, dIf.vSync, dIf.de, dIf.readEn, dIf.frameStart, dIf.fbShown, dIf.x, dIf.y, dIf.readAddr};
    nVec++; if (obsM !== 50'd0) begin nErr++; $display("FAIL reset_m got=%h exp=0", obsM); end
    nVec++; if (obsS !== 50'd0) begin nErr++; $display("FAIL reset_s got=%h exp=0", obsS); end
    nVec++; if (obsD !== 50'd0) begin nErr++; $display("FAIL reset_d got=%h exp=0", obsD); end
    reset = 1'b0;
  endtask

  task automatic test_two_frames();
    logic [49:0] obs, exp;
    int riseAt[2];
    int nRise = 0, vHigh = 0, hHigh = 0, deCnt = 0;
    logic prevV = 1'b0;
    mIf.fbHDMI = 1'b0;
    applyReset();
    for (int k = 0; k < 480; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {mIf.hSync, mIf.vSync, mIf.de, mIf.readEn, mIf.frameStart, mIf.fbShown, mIf.x, mIf.y, mIf.de ? 24'(mIf.readAddr) : 24'd0};
      exp = expVec(k, MHA, MHF, MHS, MHB, MVA, MVF, MVS, MVB, MB0, MB1, 1'b0, MAW);
      nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL frames k=%0d got=%h exp=%h", k, obs, exp); end
      if (mIf.vSync && !prevV && nRise < 2) begin riseAt[nRise] = k; nRise++; end
      prevV = mIf.vSync;
      vHigh += int'(mIf.vSync);
      hHigh += int'(mIf.hSync);
      deCnt += int'(mIf.de);
      if (k == 135) begin
        nVec++;
        if (mIf.readAddr !== 12'd100) begin nErr++; $display("FAIL last_pixel_addr got=%0d exp=100", mIf.readAddr); end
      end
    end
    nVec++; if (nRise !== 2) begin nErr++; $display("FAIL vsync_rises got=%0d exp=2", nRise); end
    nVec++; if (nRise == 2 && riseAt[1] - riseAt[0] !== 240) begin nErr++; $display("FAIL vsync_period got=%0d exp=240", riseAt[1] - riseAt[0]); end
    nVec++; if (vHigh !== 96) begin nErr++; $display("FAIL vsync_high got=%0d exp=96", vHigh); end
    nVec++; if (hHigh !== 60) begin nErr++; $display("FAIL hsync_high got=%0d exp=60", hHigh); end
    nVec++; if (deCnt !== 192) begin nErr++; $display("FAIL de_count got=%0d exp=192", deCnt); end
  endtask

  task automatic test_switch();
    logic [49:0] obs, exp;
    mIf.fbHDMI = 1'b0;
    applyReset();
    for (int k = 0; k < 480; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {mIf.hSync, mIf.vSync, mIf.de, mIf.readEn, mIf.frameStart, mIf.fbShown, mIf.x, mIf.y, mIf.de ? 24'(mIf.readAddr) : 24'd0};
      exp = expVec(k, MHA, MHF, MHS, MHB, MVA, MVF, MVS, MVB, MB0, MB1, k >= 240, MAW);
      nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL switch k=%0d got=%h exp=%h", k, obs, exp); end
      if (k == 240) begin
        nVec++;
        if (mIf.readAddr !== 12'd200 || mIf.fbShown !== 1'b1) begin
          nErr++; $display("FAIL switch_first addr=%0d fb=%b exp addr=200 fb=1", mIf.readAddr, mIf.fbShown);
        end
      end
      if (k == 2 * 24 - 1) mIf.fbHDMI = 1'b1;
    end
    mIf.fbHDMI = 1'b0;
  endtask

  task automatic test_pulse();
    logic [49:0] obs, exp;
    mIf.fbHDMI = 1'b0;
    applyReset();
    for (int k = 0; k < 720; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {mIf.hSync, mIf.vSync, mIf.de, mIf.readEn, mIf.frameStart, mIf.fbShown, mIf.x, mIf.y, mIf.de ? 24'(mIf.readAddr) : 24'd0};
      exp = expVec(k, MHA, MHF, MHS, MHB, MVA, MVF, MVS, MVB, MB0, MB1, k >= 480, MAW);
      nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL pulse k=%0d got=%h exp=%h", k, obs, exp); end
      // 5-cycle pulse mid-frame is ignored; a 1-cycle pulse exactly at (0,0) is taken.
      if (k == 30)  mIf.fbHDMI = 1'b1;
      if (k == 35)  mIf.fbHDMI = 1'b0;
      if (k == 479) mIf.fbHDMI = 1'b1;
      if (k == 480) mIf.fbHDMI = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    logic [49:0] obs, exp;
    mIf.fbHDMI = 1'b0;
    applyReset();
    repeat (82) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); @(negedge clk);
      obs = {mIf.hSync, mIf.vSync, mIf.de, mIf.readEn, mIf.frameStart, mIf.fbShown, mIf.x, mIf.y, 24'(mIf.readAddr)};
      nVec++;
      if (obs !== 50'd0) begin nErr++; $display("FAIL midreset r=%0d got=%h exp=0", r, obs); end
    end
    reset = 1'b0;
    for (int k = 0; k < 240; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {mIf.hSync, mIf.vSync, mIf.de, mIf.readEn, mIf.frameStart, mIf.fbShown, mIf.x, mIf.y, mIf.de ? 24'(mIf.readAddr) : 24'd0};
      exp = expVec(k, MHA, MHF, MHS, MHB, MVA, MVF, MVS, MVB, MB0, MB1, 1'b0, MAW);
      nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL restart k=%0d got=%h exp=%h", k, obs, exp); end
    end
  endtask

  task automatic test_small();
    logic [49:0] obs, exp;
    sIf.fbHDMI = 1'b0;
    applyReset();
    for (int k = 0; k < 126; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {sIf.hSync, sIf.vSync, sIf.de, sIf.readEn, sIf.frameStart, sIf.fbShown, sIf.x, sIf.y, sIf.de ? 24'(sIf.readAddr) : 24'd0};
      exp = expVec(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SB0, SB1, k >= 84, SAW);
      nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL small k=%0d got=%h exp=%h", k, obs, exp); end
      if (k == 17) begin
        nVec++;
        if (sIf.readAddr !== 4'd11) begin nErr++; $display("FAIL small_last got=%0d exp=11", sIf.readAddr); end
      end
      if (k == 101) begin
        nVec++;
        if (sIf.readAddr !== 4'd7) begin nErr++; $display("FAIL small_wrap got=%0d exp=7", sIf.readAddr); end
      end
      if (k == 50) sIf.fbHDMI = 1'b1;
    end
    sIf.fbHDMI = 1'b0;
  endtask

  task automatic test_default_lines();
    logic [49:0] obs, exp;
    int hHigh = 0, deCnt = 0;
    dIf.fbHDMI = 1'b0;
    applyReset();
    for (int k = 0; k < 1600; k++) begin
      @(posedge clk); @(negedge clk);
      obs = {dIf.hSync, dIf.vSync, dIf.de, dIf.readEn, dIf.frameStart, dIf.fbShown, dIf.x, dIf.y, dIf.de ? dIf.readAddr : 24'd0};
      exp = expVec(k, 640, 16, 96, 48, 480, 10, 2, 33, 0, 307200, 1'b0, 24);
      nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL default k=%0d got=%h exp=%h", k, obs, exp); end
      hHigh += int'(dIf.hSync);
      deCnt += int'(dIf.de);
    end
    nVec++; if (hHigh !== 192) begin nErr++; $display("FAIL default_hsync got=%0d exp=192", hHigh); end
    nVec++; if (deCnt !== 1280) begin nErr++; $display("FAIL default_de got=%0d exp=1280", deCnt); end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_switch();
    test_pulse();
    test_reset_midframe();
    test_small();
    test_default_lines();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
